mono_rx_readout_seq: RTL and testbench

Programmable readout sequencer for the MONOPIX token-based serial readout. It sits in the CLK_BX domain ahead of the RX deserializer/CDC FIFO and generates the RX_FREEZE/RX_READ timing toward the chip. Phase lengths come from static configuration, and the block stalls between reads when the downstream FIFO signals full. It also counts completed reads and can stop after a programmed number of hits.

---
 rtl/mono_rx_readout_seq.sv | 78 +++++++
 tb/tb_mono_rx_readout_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mono_rx_readout_seq.sv
// mono_rx_readout_seq: MONOPIX token readout sequencer driving RX_FREEZE/RX_READ
//   CLK_BX, RST          : clock, synchronous active-high reset
//   CONF_EN              : enable; its rising edge clears READ_CNT and DONE
//   CONF_TOKEN_WAIT/READ_LEN/DATA_LEN : phase lengths minus 1 (static while BUSY)
//   CONF_MAX_READS       : stop after this many reads, 0 = unlimited
//   RX_TOKEN, BACKPRESSURE : chip token, downstream FIFO full
//   RX_FREEZE, RX_READ, BUSY, READ_CNT, DONE : registered status/strobes
module mono_rx_readout_seq #(
  parameter int CNT_WIDTH  = 8,
  parameter int RCNT_WIDTH = 16
) (
  input  logic                  CLK_BX,
  input  logic                  RST,
  input  logic                  CONF_EN,
  input  logic [CNT_WIDTH-1:0]  CONF_TOKEN_WAIT,
  input  logic [CNT_WIDTH-1:0]  CONF_READ_LEN,
  input  logic [CNT_WIDTH-1:0]  CONF_DATA_LEN,
  input  logic [RCNT_WIDTH-1:0] CONF_MAX_READS,
  input  logic                  RX_TOKEN,
  input  logic                  BACKPRESSURE,
  output logic                  RX_FREEZE,
  output logic                  RX_READ,
  output logic                  BUSY,
  output logic [RCNT_WIDTH-1:0] READ_CNT,
  output logic                  DONE
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DATA, S_HOLD} state_t;
  state_t                r_state;
  state_t                w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_en_d;
  logic                  w_en_rise;
  logic                  w_data_last;
  logic                  w_limit;
  logic [RCNT_WIDTH:0]   w_cnt_inc;
  logic [RCNT_WIDTH-1:0] w_cnt_sat;
  assign w_en_rise   = CONF_EN & ~r_en_d;
  assign w_data_last = (r_state == S_DATA) && (r_cnt == CONF_DATA_LEN);
  // unsaturated READ_CNT+1 so the limit compare is exact even at all-ones
  assign w_cnt_inc   = {1'b0, READ_CNT} + (RCNT_WIDTH+1)'(1);
  assign w_cnt_sat   = &READ_CNT ? READ_CNT : w_cnt_inc[RCNT_WIDTH-1:0];
  assign w_limit     = (CONF_MAX_READS != '0) && (w_cnt_inc >= {1'b0, CONF_MAX_READS});
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (CONF_EN & RX_TOKEN & ~DONE & ~BACKPRESSURE) w_next = S_WAIT;
      S_WAIT: if (r_cnt == CONF_TOKEN_WAIT) w_next = S_READ;
      S_READ: if (r_cnt == CONF_READ_LEN) w_next = S_DATA;
      S_DATA: if (w_data_last) w_next = (w_limit || !CONF_EN) ? S_IDLE :
                                         BACKPRESSURE        ? S_HOLD :
                                         RX_TOKEN            ? S_WAIT : S_IDLE;
      S_HOLD: if (!BACKPRESSURE) w_next = (RX_TOKEN & CONF_EN) ? S_WAIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // outputs decode w_next so they line up with the state register
  always_ff @(posedge CLK_BX) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_en_d    <= 1'b0;
      RX_FREEZE <= 1'b0;
      RX_READ   <= 1'b0;
      BUSY      <= 1'b0;
      READ_CNT  <= '0;
      DONE      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_en_d    <= CONF_EN;
      r_cnt     <= (w_next != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + CNT_WIDTH'(1));
      RX_FREEZE <= w_next != S_IDLE;
      RX_READ   <= w_next == S_READ;
      BUSY      <= w_next != S_IDLE;
      READ_CNT  <= w_en_rise ? '0 : (w_data_last ? w_cnt_sat : READ_CNT);
      DONE      <= w_en_rise ? 1'b0 : ((w_data_last & w_limit) ? 1'b1 : DONE);
    end
  end
endmodule

// File: tb/tb_mono_rx_readout_seq.sv
// tb_mono_rx_readout_seq: randomized bench with a phase/remaining-cycles reference model
module tb_mono_rx_readout_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        tok = 1'b0;
  logic        bp = 1'b0;
  logic [7:0]  tw = '0;
  logic [7:0]  rl = '0;
  logic [7:0]  dl = '0;
  logic [15:0] mx = '0;
  logic        freeze;
  logic        rd_o;
  logic        busy;
  logic [15:0] rcnt;
  logic        done;
  int          pass_n = 0;
  int          tot_n = 0;
  bit          chk_en = 0;
  int          m_ph = 0;
  int          m_left = 0;
  int          m_cnt = 0;
  bit          m_done = 0;
  bit          m_en_prev = 0;
  bit          rise;
  bit          lim;
  mono_rx_readout_seq #(.CNT_WIDTH(8), .RCNT_WIDTH(16)) dut (
    .CLK_BX(clk), .RST(rst), .CONF_EN(en),
    .CONF_TOKEN_WAIT(tw), .CONF_READ_LEN(rl), .CONF_DATA_LEN(dl),
    .CONF_MAX_READS(mx), .RX_TOKEN(tok), .BACKPRESSURE(bp),
    .RX_FREEZE(freeze), .RX_READ(rd_o), .BUSY(busy), .READ_CNT(rcnt), .DONE(done)
  );
  always #5 clk = ~clk;
  task automatic check(string name, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  // model: phase 0 idle,1 wait,2 read,3 data,4 hold; m_left = cycles still to go after this one
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_left = 0; m_cnt = 0; m_done = 0; m_en_prev = 0;
    end else begin
      rise = en && !m_en_prev;
      m_en_prev = en;
      case (m_ph)
        0: if (en && tok && !m_done && !bp) begin m_ph = 1; m_left = tw; end
        1: if (m_left == 0) begin m_ph = 2; m_left = rl; end else m_left--;
        2: if (m_left == 0) begin m_ph = 3; m_left = dl; end else m_left--;
        3: if (m_left > 0) m_left--;
           else begin
             lim = (mx != 0) && (m_cnt + 1 >= mx);
             if (m_cnt < 65535) m_cnt++;
             if (lim) begin m_done = 1; m_ph = 0; end
             else if (!en) m_ph = 0;
             else if (bp) m_ph = 4;
             else if (tok) begin m_ph = 1; m_left = tw; end
             else m_ph = 0;
           end
        4: if (!bp) begin
             if (tok && en) begin m_ph = 1; m_left = tw; end
             else m_ph = 0;
           end
        default: m_ph = 0;
      endcase
      if (rise) begin m_cnt = 0; m_done = 0; end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("freeze", freeze, m_ph != 0);
      check("read", rd_o, m_ph == 2);
      check("busy", busy, m_ph != 0);
      check("read_cnt", rcnt, m_cnt);
      check("done", done, m_done);
    end
  end
  initial begin
    int fz, rd, by, ff, rf, pulses;
    bit prev;
    repeat (2) @(negedge clk);
    check("rst_freeze", freeze, 0);
    check("rst_read", rd_o, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", rcnt, 0);
    check("rst_done", done, 0);
    tw = 2; rl = 3; dl = 5; mx = 0; en = 1; rst = 0; chk_en = 1;
    repeat (2) @(negedge clk);
    tok = 1;
    fz = 0; rd = 0; by = 0; ff = -1; rf = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) tok = 0;
      if (freeze) begin fz++; if (ff < 0) ff = i; end
      if (rd_o) begin rd++; if (rf < 0) rf = i; end
      if (busy) by++;
    end
    check("single_freeze_len", fz, 13);
    check("single_read_len", rd, 4);
    check("single_read_offset", rf - ff, 3);
    check("single_busy_len", by, 13);
    check("single_read_cnt", rcnt, 1);
    en = 0; @(negedge clk);
    en = 1; repeat (2) @(negedge clk);
    mx = 2; tok = 1; pulses = 0; prev = 0; fz = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_o && !prev) pulses++;
      prev = rd_o;
      if (freeze) fz++;
    end
    check("max_pulses", pulses, 2);
    check("max_freeze_b2b", fz, 26);
    check("max_done", done, 1);
    check("max_cnt", rcnt, 2);
    check("max_idle", busy, 0);
    en = 0; @(negedge clk);
    en = 1; @(negedge clk);
    check("reen_done", done, 0);
    check("reen_cnt", rcnt, 0);
    repeat (4) @(negedge clk);
    check("reen_resume", busy, 1);
    tok = 0; repeat (40) @(negedge clk);
    en = 0; tw = 0; rl = 0; dl = 0; mx = 0; @(negedge clk);
    en = 1; repeat (2) @(negedge clk);
    tok = 1; fz = 0; rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) tok = 0;
      if (freeze) fz++;
      if (rd_o) rd++;
    end
    check("zero_freeze_len", fz, 3);
    check("zero_read_len", rd, 1);
    tok = 1; repeat (3) @(negedge clk);
    rst = 1; @(negedge clk);
    check("mid_rst_freeze", freeze, 0);
    check("mid_rst_read", rd_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", rcnt, 0);
    check("mid_rst_done", done, 0);
    rst = 0; tok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(399) == 0);
      tok = ($urandom_range(3) != 0);
      bp = ($urandom_range(4) == 0);
      en = ($urandom_range(49) != 0);
      if (m_ph == 0 && $urandom_range(7) == 0) begin
        tw = 8'($urandom_range(3));
        rl = 8'($urandom_range(3));
        dl = 8'($urandom_range(3));
        mx = 16'($urandom_range(4));
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
